textlcd_monitor: RTL and testbench

Passive responder for the character-LCD bus that our text LCD driver produces. It watches lcd_e/lcd_rs/lcd_rw/lcd_data, decodes HD44780-style instructions and data writes on the falling edge of E, and keeps a 2x16 shadow DDRAM plus display-control state. Logic can read the mirror back through a read port, for on-chip self-check or for a second display path.

---
 rtl/textlcd_monitor.sv | 164 ++++++++++++++++
 tb/tb_textlcd_monitor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/textlcd_monitor.sv
// rtl/textlcd_monitor.sv - passive HD44780-style bus monitor with a 2x16 DDRAM shadow
module textlcd_monitor #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] BLANK_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char,
  output logic [6:0] cur_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       inc_mode,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_code,
  output logic       err
);

  typedef enum logic {ST_IDLE, ST_CLEARING} state_t;

  // bus bundle: {e, rs, rw, data[7:0]} moves through the synchronizer as one word
  logic [10:0] sync_q [SYNC_STAGES];
  logic        e_prev_q;

  state_t      state_q;
  logic [7:0]  mirror_q [32];
  logic [4:0]  clr_idx_q;
  logic [6:0]  ac_q;
  logic [7:0]  rd_char_q;
  logic        disp_on_q, cursor_on_q, blink_on_q, two_line_q, inc_mode_q;
  logic        busy_q, cmd_valid_q, cmd_rs_q, err_q;
  logic [7:0]  cmd_code_q;

  logic [10:0] bus_s;
  logic        s_e, s_rs, s_rw;
  logic [7:0]  s_data;
  logic        fall, accept, drop;

  assign bus_s  = sync_q[SYNC_STAGES-1];
  assign s_e    = bus_s[10];
  assign s_rs   = bus_s[9];
  assign s_rw   = bus_s[8];
  assign s_data = bus_s[7:0];
  assign fall   = e_prev_q & ~s_e;
  assign accept = fall & ~s_rw & ~busy_q;
  assign drop   = fall & (s_rw | busy_q);

  function automatic logic [6:0] ac_up(input logic [6:0] a);
    if (a == 7'h27)      return 7'h40;
    else if (a == 7'h67) return 7'h00;
    else                 return a + 7'd1;
  endfunction

  function automatic logic [6:0] ac_down(input logic [6:0] a);
    if (a == 7'h00)      return 7'h67;
    else if (a == 7'h40) return 7'h27;
    else                 return a - 7'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      e_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {lcd_e, lcd_rs, lcd_rw, lcd_data};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      e_prev_q <= s_e;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 32; i++) mirror_q[i] <= BLANK_CHAR;
      clr_idx_q   <= '0;
      ac_q        <= '0;
      rd_char_q   <= BLANK_CHAR;
      disp_on_q   <= 1'b0;
      cursor_on_q <= 1'b0;
      blink_on_q  <= 1'b0;
      two_line_q  <= 1'b0;
      inc_mode_q  <= 1'b1;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_rs_q    <= 1'b0;
      cmd_code_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      cmd_valid_q <= accept;
      err_q       <= drop;
      rd_char_q   <= mirror_q[rd_addr];
      if (accept) begin
        cmd_rs_q   <= s_rs;
        cmd_code_q <= s_data;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (s_rs) begin
              // only columns 0..15 of each line are shadowed
              if (ac_q[5:4] == 2'b00) mirror_q[{ac_q[6], ac_q[3:0]}] <= s_data;
              ac_q <= inc_mode_q ? ac_up(ac_q) : ac_down(ac_q);
            end else begin
              casez (s_data)
                8'b1???????: ac_q <= s_data[6:0];
                8'b01??????: begin end
                8'b001?????: two_line_q <= s_data[3];
                8'b0001????: begin
                  if (!s_data[3]) ac_q <= s_data[2] ? ac_up(ac_q) : ac_down(ac_q);
                end
                8'b00001???: begin
                  disp_on_q   <= s_data[2];
                  cursor_on_q <= s_data[1];
                  blink_on_q  <= s_data[0];
                end
                8'b000001??: inc_mode_q <= s_data[1];
                8'b0000001?: ac_q <= 7'h00;
                8'b00000001: begin
                  ac_q       <= 7'h00;
                  inc_mode_q <= 1'b1;
                  busy_q     <= 1'b1;
                  clr_idx_q  <= 5'd0;
                  state_q    <= ST_CLEARING;
                end
                default: begin end
              endcase
            end
          end
        end
        ST_CLEARING: begin
          mirror_q[clr_idx_q] <= BLANK_CHAR;
          clr_idx_q           <= clr_idx_q + 5'd1;
          if (clr_idx_q == 5'd31) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_char   = rd_char_q;
  assign cur_addr  = ac_q;
  assign disp_on   = disp_on_q;
  assign cursor_on = cursor_on_q;
  assign blink_on  = blink_on_q;
  assign two_line  = two_line_q;
  assign inc_mode  = inc_mode_q;
  assign busy      = busy_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rs    = cmd_rs_q;
  assign cmd_code  = cmd_code_q;
  assign err       = err_q;

endmodule

// File: tb/tb_textlcd_monitor.sv
// tb/tb_textlcd_monitor.sv - self-checking bench for textlcd_monitor
module tb_textlcd_monitor;
  localparam int SYNC = 2;
  localparam int BLANK = 'h20;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char, cmd_code;
  logic [6:0] cur_addr;
  logic       disp_on, cursor_on, blink_on, two_line, inc_mode, busy, cmd_valid, cmd_rs, err;

  textlcd_monitor #(.SYNC_STAGES(SYNC), .BLANK_CHAR(8'h20)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_char(rd_char), .cur_addr(cur_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on), .two_line(two_line),
    .inc_mode(inc_mode), .busy(busy), .cmd_valid(cmd_valid), .cmd_rs(cmd_rs),
    .cmd_code(cmd_code), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  // model state
  int mir [32];
  int m_ac, m_inc, m_disp, m_cur, m_blink, m_two, m_busy, m_busy_before;
  int m_valid, m_err, m_rs, m_code, clr_left, exp_rd;
  // observations of the DUT used by literal checks
  int busy_prev = 0, busy_run = 0, last_run = 0, n_valid = 0, n_errp = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ac_up(input int a);
    if (a == 'h27) return 'h40;
    if (a == 'h67) return 0;
    return a + 1;
  endfunction

  function automatic int ac_down(input int a);
    if (a == 0) return 'h67;
    if (a == 'h40) return 'h27;
    return a - 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mir[i] = BLANK;
    m_ac = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0;
    m_busy = 0; m_busy_before = 0; m_valid = 0; m_err = 0; m_rs = 0; m_code = 0;
    clr_left = 0; exp_rd = BLANK;
  endtask

  task automatic model_apply(input int rs, input int rw, input int d);
    if (rw != 0 || m_busy_before != 0) begin
      m_err = 1;
      return;
    end
    m_valid = 1; m_rs = rs; m_code = d;
    if (rs != 0) begin
      if ((m_ac % 64) < 16) mir[(m_ac / 64) * 16 + (m_ac % 16)] = d;
      m_ac = (m_inc != 0) ? ac_up(m_ac) : ac_down(m_ac);
    end else if (d >= 'h80) m_ac = d - 'h80;
    else if (d >= 'h40) begin end
    else if (d >= 'h20) m_two = (d / 8) % 2;
    else if (d >= 'h10) begin
      if ((d / 8) % 2 == 0) m_ac = ((d / 4) % 2 != 0) ? ac_up(m_ac) : ac_down(m_ac);
    end else if (d >= 8) begin
      m_disp = (d / 4) % 2; m_cur = (d / 2) % 2; m_blink = d % 2;
    end else if (d >= 4) m_inc = (d / 2) % 2;
    else if (d >= 2) m_ac = 0;
    else if (d == 1) begin
      m_ac = 0; m_inc = 1; m_busy = 1; clr_left = 32;
    end
  endtask

  // per-edge model bookkeeping: registered read, pulse expiry, clear countdown
  always @(posedge clk) begin
    exp_rd = mir[rd_addr];
    m_busy_before = m_busy;
    m_valid = 0;
    m_err = 0;
    if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0) begin
        m_busy = 0;
        for (int i = 0; i < 32; i++) mir[i] = BLANK;
      end
    end
  end

  always @(negedge clk) begin
    chk("cur_addr", cur_addr, m_ac);
    chk("inc_mode", inc_mode, m_inc);
    chk("disp_on", disp_on, m_disp);
    chk("cursor_on", cursor_on, m_cur);
    chk("blink_on", blink_on, m_blink);
    chk("two_line", two_line, m_two);
    chk("busy", busy, m_busy);
    chk("cmd_valid", cmd_valid, m_valid);
    chk("err", err, m_err);
    chk("cmd_rs", cmd_rs, m_rs);
    chk("cmd_code", cmd_code, m_code);
    if (m_busy == 0 && busy_prev == 0) chk("rd_char", rd_char, exp_rd);
    busy_prev = m_busy;
    if (cmd_valid) n_valid++;
    if (err) n_errp++;
    if (busy) busy_run++;
    else begin
      if (busy_run > 0) last_run = busy_run;
      busy_run = 0;
    end
  end

  task automatic bus_ev(input int rs, input int rw, input int d);
    @(posedge clk); #1;
    lcd_rs = rs[0]; lcd_rw = rw[0]; lcd_data = d[7:0];
    repeat (2) @(posedge clk); #1;
    lcd_e = 1'b1;
    repeat (3) @(posedge clk); #1;
    lcd_e = 1'b0;
    repeat (SYNC + 1) @(posedge clk); #1;
    model_apply(rs, rw, d);
    repeat (2) @(posedge clk);
  endtask

  task automatic read_lit(input string name, input int a, input int exp);
    @(posedge clk); #1;
    rd_addr = a[4:0];
    @(posedge clk);
    @(negedge clk);
    chk(name, rd_char, exp);
  endtask

  task automatic write_str(input int start_cmd, input int s [5]);
    bus_ev(0, 0, start_cmd);
    for (int i = 0; i < 5; i++) bus_ev(1, 0, s[i]);
  endtask

  task automatic init_seq();
    bus_ev(0, 0, 'h3C);
    bus_ev(0, 0, 'h0C);
    bus_ev(0, 0, 'h06);
  endtask

  int hello [5] = '{'h48, 'h65, 'h6C, 'h6C, 'h6F};
  int world [5] = '{'h57, 'h6F, 'h72, 'h6C, 'h64};

  initial begin
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cur_addr", cur_addr, 0);
    chk("rst_inc_mode", inc_mode, 1);
    chk("rst_rd_char", rd_char, 'h20);
    @(posedge clk); #1 rst = 1'b1;

    n_valid = 0;
    init_seq();
    chk("init_two_line", two_line, 1);
    chk("init_disp_on", disp_on, 1);
    chk("init_cursor_on", cursor_on, 0);
    chk("init_pulses", n_valid, 3);

    write_str('h80, hello);
    chk("hello_ac", cur_addr, 'h05);
    for (int i = 0; i < 5; i++) read_lit("hello_char", i, hello[i]);
    write_str('hC0, world);
    chk("world_ac", cur_addr, 'h45);
    for (int i = 0; i < 5; i++) read_lit("world_char", 16 + i, world[i]);

    // cursor shifts, display shift, CGRAM and null instructions
    bus_ev(0, 0, 'h14);
    chk("shift_right", cur_addr, 'h46);
    bus_ev(0, 0, 'h10);
    bus_ev(0, 0, 'h1C);
    bus_ev(0, 0, 'h48);
    bus_ev(0, 0, 'h00);
    chk("shift_hold", cur_addr, 'h45);

    // clear with a data write attempted mid-clear
    n_errp = 0;
    bus_ev(0, 0, 'h01);
    bus_ev(1, 0, 'h5A);
    repeat (40) @(posedge clk);
    chk("busy_len", last_run, 32);
    chk("busy_err", n_errp, 1);
    chk("clear_ac", cur_addr, 0);
    for (int i = 0; i < 32; i++) read_lit("clear_blank", i, 'h20);

    bus_ev(0, 0, 'hA7);
    bus_ev(1, 0, 'h41);
    chk("wrap_27_40", cur_addr, 'h40);
    bus_ev(0, 0, 'h8F);
    bus_ev(1, 0, 'h42);
    chk("col15_ac", cur_addr, 'h10);
    read_lit("col15_char", 15, 'h42);
    bus_ev(1, 1, 'h55);
    chk("rw_err", n_errp, 2);

    // decrement wrap 0x00 -> 0x67, then increment wrap 0x67 -> 0x00
    bus_ev(0, 0, 'h80);
    bus_ev(0, 0, 'h04);
    bus_ev(1, 0, 'h58);
    chk("wrap_00_67", cur_addr, 'h67);
    bus_ev(0, 0, 'h06);
    bus_ev(1, 0, 'h59);
    chk("wrap_67_00", cur_addr, 0);
    read_lit("dec_char", 0, 'h58);

    // reset in the middle of a clear
    bus_ev(0, 0, 'h01);
    repeat (8) @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_two_line", two_line, 0);
    chk("mid_rst_cmd_code", cmd_code, 0);
    chk("mid_rst_rd_char", rd_char, 'h20);
    repeat (2) @(posedge clk); #1 rst = 1'b1;
    init_seq();
    write_str('h80, hello);
    for (int i = 0; i < 5; i++) read_lit("rehello_char", i, hello[i]);
    read_lit("rehello_blank", 15, 'h20);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
